// File: rtl/mvu_wgt_streamer_pkg.sv
// Shared definitions for the MVU weight streamer: default geometry, the SIMD word type
// and a width helper that never returns zero.
package mvu_wgt_streamer_pkg;

  localparam int unsigned DefSimd    = 4;
  localparam int unsigned DefPe      = 2;
  localparam int unsigned DefTw      = 1;
  localparam int unsigned DefMatrixW = 16;
  localparam int unsigned DefMatrixH = 4;

  typedef logic [0:DefSimd-1][DefTw-1:0] wgt_simd_t;

  // Index widths for selects that may have a single legal value still need one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvu_wgt_streamer_mem.sv
// Per-PE weight RAM: one write port, one registered read port, read-first on collision.
module mvu_wgt_streamer_mem
  import mvu_wgt_streamer_pkg::*;
#(
  parameter int unsigned Width = DefSimd * DefTw,
  parameter int unsigned AW    = 3
) (
  input  logic             clk_i,
  input  logic             wen_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             ren_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  // Padded to a power of two so every address value indexes a real entry.
  logic [Width-1:0] mem_q [2**AW];
  logic [Width-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (wen_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (ren_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mvu_wgt_streamer.sv
// Streams the folded weight matrix to the PE array, one SIMD word per PE per beat, with
// sf_clr/sf_last framing and a 2-entry skid buffer behind the synchronous RAM read.
module mvu_wgt_streamer
  import mvu_wgt_streamer_pkg::*;
#(
  parameter  int unsigned SIMD    = DefSimd,
  parameter  int unsigned PE      = DefPe,
  parameter  int unsigned TW      = DefTw,
  parameter  int unsigned MatrixW = DefMatrixW,
  parameter  int unsigned MatrixH = DefMatrixH,
  localparam int unsigned SF      = MatrixW / SIMD,
  localparam int unsigned NF      = MatrixH / PE,
  localparam int unsigned AW      = clog2_min1(SF * NF),
  localparam int unsigned PW      = clog2_min1(PE),
  localparam int unsigned NW      = clog2_min1(NF)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wmem_wen_i,
  input  logic [PW-1:0]          wmem_pe_sel_i,
  input  logic [AW-1:0]          wmem_addr_i,
  input  logic [SIMD*TW-1:0]     wmem_wdata_i,
  input  logic                   en_i,
  input  logic                   restart_i,
  output logic [PE*SIMD*TW-1:0]  out_wgt_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   out_sf_clr_o,
  output logic                   out_sf_last_o,
  output logic [NW-1:0]          out_nf_o
);

  localparam int unsigned WordW = SIMD * TW;
  localparam int unsigned BeatW = PE * WordW;
  localparam int unsigned SW    = clog2_min1(SF);

  logic [SW-1:0]    sf_q, sf_d;
  logic [NW-1:0]    nf_q, nf_d;
  logic             in_flight_q, in_flight_d;
  logic             fl_clr_q, fl_last_q;
  logic [NW-1:0]    fl_nf_q;
  logic [1:0]       cnt_q, cnt_d;
  logic             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [BeatW-1:0] fifo_data_q [2];
  logic             fifo_clr_q  [2];
  logic             fifo_last_q [2];
  logic [NW-1:0]    fifo_nf_q   [2];

  logic             out_valid, handshake, issue, push, pop_fifo;
  logic [AW-1:0]    rd_addr;
  logic [BeatW-1:0] rd_beat;

  assign rd_addr = AW'(32'(nf_q) * SF + 32'(sf_q));

  for (genvar p = 0; p < PE; p++) begin : g_pe
    logic [WordW-1:0] rdata;

    mvu_wgt_streamer_mem #(
      .Width(WordW),
      .AW   (AW)
    ) u_mem (
      .clk_i  (clk_i),
      .wen_i  (wmem_wen_i && (wmem_pe_sel_i == PW'(p))),
      .waddr_i(wmem_addr_i),
      .wdata_i(wmem_wdata_i),
      .ren_i  (issue),
      .raddr_i(rd_addr),
      .rdata_o(rdata)
    );

    // PE 0 occupies the most significant word of the beat.
    assign rd_beat[(PE-1-p)*WordW +: WordW] = rdata;
  end

  always_comb begin
    out_valid = (cnt_q != 2'd0) || in_flight_q;
    handshake = out_valid && out_ready_i;
    // Credit check counts the RAM output stage so the skid buffer can never overflow.
    issue     = en_i && !restart_i && ((cnt_q + {1'b0, in_flight_q}) < 2'd2);
    pop_fifo  = handshake && (cnt_q != 2'd0);
    // An empty buffer lets the RAM output be consumed directly instead of being queued.
    push      = in_flight_q && !(handshake && (cnt_q == 2'd0));

    sf_d = sf_q;
    nf_d = nf_q;
    if (issue) begin
      if (sf_q == SW'(SF - 1)) begin
        sf_d = '0;
        nf_d = (nf_q == NW'(NF - 1)) ? '0 : nf_q + 1'b1;
      end else begin
        sf_d = sf_q + 1'b1;
      end
    end

    cnt_d       = cnt_q + {1'b0, push} - {1'b0, pop_fifo};
    wr_ptr_d    = push ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d    = pop_fifo ? ~rd_ptr_q : rd_ptr_q;
    in_flight_d = issue;

    if (restart_i) begin
      sf_d     = '0;
      nf_d     = '0;
      cnt_d    = '0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_o   = out_valid;
    out_wgt_o     = '0;
    out_sf_clr_o  = 1'b0;
    out_sf_last_o = 1'b0;
    out_nf_o      = '0;
    if (cnt_q != 2'd0) begin
      out_wgt_o     = fifo_data_q[rd_ptr_q];
      out_sf_clr_o  = fifo_clr_q[rd_ptr_q];
      out_sf_last_o = fifo_last_q[rd_ptr_q];
      out_nf_o      = fifo_nf_q[rd_ptr_q];
    end else if (in_flight_q) begin
      out_wgt_o     = rd_beat;
      out_sf_clr_o  = fl_clr_q;
      out_sf_last_o = fl_last_q;
      out_nf_o      = fl_nf_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sf_q        <= '0;
      nf_q        <= '0;
      in_flight_q <= 1'b0;
      fl_clr_q    <= 1'b0;
      fl_last_q   <= 1'b0;
      fl_nf_q     <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      sf_q        <= sf_d;
      nf_q        <= nf_d;
      in_flight_q <= in_flight_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      if (issue) begin
        fl_clr_q  <= (sf_q == '0);
        fl_last_q <= (sf_q == SW'(SF - 1));
        fl_nf_q   <= nf_q;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= rd_beat;
      fifo_clr_q[wr_ptr_q]  <= fl_clr_q;
      fifo_last_q[wr_ptr_q] <= fl_last_q;
      fifo_nf_q[wr_ptr_q]   <= fl_nf_q;
    end
  end

endmodule

// File: tb/tb_mvu_wgt_streamer.sv
// Directed bench for mvu_wgt_streamer: default geometry (SF=4, NF=2) plus an SF=1/NF=1 copy.
module tb_mvu_wgt_streamer;

  logic       clk;
  logic       rst;
  logic       wen, en, restart, ready;
  logic [0:0] pe_sel;
  logic [2:0] waddr;
  logic [3:0] wdata;
  logic [7:0] out_wgt;
  logic       out_valid, out_clr, out_last;
  logic [0:0] out_nf;

  logic       wen2, en2, restart2, ready2;
  logic [0:0] pe_sel2;
  logic [0:0] waddr2;
  logic [3:0] wdata2;
  logic [7:0] out_wgt2;
  logic       out_valid2, out_clr2, out_last2;
  logic [0:0] out_nf2;

  logic [11:0] obs, obs2;
  int n_checks = 0;
  int n_fail   = 0;

  assign obs  = {out_valid, out_wgt, out_clr, out_last, out_nf};
  assign obs2 = {out_valid2, out_wgt2, out_clr2, out_last2, out_nf2};

  mvu_wgt_streamer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .wmem_wen_i   (wen),
    .wmem_pe_sel_i(pe_sel),
    .wmem_addr_i  (waddr),
    .wmem_wdata_i (wdata),
    .en_i         (en),
    .restart_i    (restart),
    .out_wgt_o    (out_wgt),
    .out_valid_o  (out_valid),
    .out_ready_i  (ready),
    .out_sf_clr_o (out_clr),
    .out_sf_last_o(out_last),
    .out_nf_o     (out_nf)
  );

  mvu_wgt_streamer #(
    .SIMD   (4),
    .PE     (2),
    .TW     (1),
    .MatrixW(4),
    .MatrixH(2)
  ) dut_sf1 (
    .clk_i        (clk),
    .rst_i        (rst),
    .wmem_wen_i   (wen2),
    .wmem_pe_sel_i(pe_sel2),
    .wmem_addr_i  (waddr2),
    .wmem_wdata_i (wdata2),
    .en_i         (en2),
    .restart_i    (restart2),
    .out_wgt_o    (out_wgt2),
    .out_valid_o  (out_valid2),
    .out_ready_i  (ready2),
    .out_sf_clr_o (out_clr2),
    .out_sf_last_o(out_last2),
    .out_nf_o     (out_nf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected beat for address a (PE0 word pe0, PE1 word ~a): {valid, wgt, clr, last, nf}.
  function automatic logic [11:0] exp_beat(input logic [3:0] a, input logic [3:0] pe0);
    return {1'b1, pe0, ~a, (a[1:0] == 2'd0), (a[1:0] == 2'd3), a[2]};
  endfunction

  task automatic restart_stream();
    @(negedge clk);
    en = 1'b0; restart = 1'b1; ready = 1'b1;
    @(negedge clk);
    restart = 1'b0; en = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, 12'h000);
    end
    n_checks++;
    if (obs2 !== 12'h000) begin
      n_fail++; $display("FAIL reset_outputs_sf1: got %h expected %h", obs2, 12'h000);
    end
    rst = 1'b0;
  endtask

  task automatic load_mem();
    for (int a = 0; a < 8; a++) begin
      for (int p = 0; p < 2; p++) begin
        @(negedge clk);
        wen = 1'b1; pe_sel = 1'(p); waddr = 3'(a);
        wdata = (p == 0) ? 4'(a) : ~4'(a);
      end
    end
    @(negedge clk);
    wen = 1'b0;
    wen2 = 1'b1; pe_sel2 = 1'b0; waddr2 = 1'b0; wdata2 = 4'hA;
    @(negedge clk);
    pe_sel2 = 1'b1; wdata2 = 4'h5;
    @(negedge clk);
    wen2 = 1'b0;
  endtask

  task automatic test_stream();
    restart_stream();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_beat(4'(i % 8), 4'(i % 8))) begin
        n_fail++;
        $display("FAIL stream_beat%0d: got %h expected %h", i, obs, exp_beat(4'(i % 8), 4'(i % 8)));
      end
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    restart_stream();
    for (int cyc = 0; cyc < 15; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_beat(4'(idx % 8), 4'(idx % 8))) begin
        n_fail++;
        $display("FAIL stall_cyc%0d: got %h expected %h", cyc, obs,
                 exp_beat(4'(idx % 8), 4'(idx % 8)));
      end
      ready = !(cyc >= 3 && cyc < 8);
      if (ready) idx++;
    end
    ready = 1'b1;
  endtask

  task automatic test_restart();
    restart_stream();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_beat(4'(k), 4'(k))) begin
        n_fail++; $display("FAIL restart_pre%0d: got %h expected %h", k, obs, exp_beat(4'(k), 4'(k)));
      end
    end
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL restart_valid_low: got %b expected 0", out_valid);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_beat(4'(k), 4'(k))) begin
        n_fail++; $display("FAIL restart_post%0d: got %h expected %h", k, obs, exp_beat(4'(k), 4'(k)));
      end
    end
  endtask

  task automatic test_sf1_nf1();
    @(negedge clk);
    en2 = 1'b1; ready2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs2 !== {1'b1, 8'hA5, 1'b1, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL sf1_beat%0d: got %h expected %h", k, obs2, {1'b1, 8'hA5, 3'b110});
      end
    end
    en2 = 1'b0;
  endtask

  task automatic test_en_drain();
    restart_stream();
    @(negedge clk);
    n_checks++;
    if (obs !== exp_beat(4'd0, 4'd0)) begin
      n_fail++; $display("FAIL drain_beat0: got %h expected %h", obs, exp_beat(4'd0, 4'd0));
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ready = 1'b0;
      n_checks++;
      if (obs !== exp_beat(4'd1, 4'd1)) begin
        n_fail++; $display("FAIL drain_hold%0d: got %h expected %h", k, obs, exp_beat(4'd1, 4'd1));
      end
    end
    en = 1'b0; ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (obs !== exp_beat(4'd2, 4'd2)) begin
      n_fail++; $display("FAIL drain_beat2: got %h expected %h", obs, exp_beat(4'd2, 4'd2));
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++; $display("FAIL drain_empty%0d: got %b expected 0", k, out_valid);
      end
    end
  endtask

  task automatic test_write_collision();
    logic [3:0] a;
    logic [3:0] pe0;
    restart_stream();
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      wen = 1'b0;
      a   = 4'(k % 8);
      pe0 = (a == 4'd5 && k >= 8) ? 4'hF : a;
      n_checks++;
      if (obs !== exp_beat(a, pe0)) begin
        n_fail++; $display("FAIL collide_beat%0d: got %h expected %h", k, obs, exp_beat(a, pe0));
      end
      if (k == 4) begin
        wen = 1'b1; pe_sel = 1'b0; waddr = 3'd5; wdata = 4'hF;
      end
    end
  endtask

  task automatic test_reset_mid();
    restart_stream();
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (obs !== exp_beat(4'd0, 4'd0)) begin
      n_fail++; $display("FAIL rstmid_full_head: got %h expected %h", obs, exp_beat(4'd0, 4'd0));
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (obs !== 12'h000) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h expected %h", obs, 12'h000);
    end
    @(negedge clk);
    rst = 1'b0; ready = 1'b1; en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== exp_beat(4'(k), 4'(k))) begin
        n_fail++; $display("FAIL rstmid_beat%0d: got %h expected %h", k, obs, exp_beat(4'(k), 4'(k)));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    wen = 1'b0; pe_sel = '0; waddr = '0; wdata = '0; en = 1'b0; restart = 1'b0; ready = 1'b0;
    wen2 = 1'b0; pe_sel2 = '0; waddr2 = '0; wdata2 = '0; en2 = 1'b0; restart2 = 1'b0;
    ready2 = 1'b0;
    test_reset();
    load_mem();
    test_stream();
    test_backpressure();
    test_restart();
    test_sf1_nf1();
    test_en_drain();
    test_write_collision();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
